// File: rtl/uart_loop_pkg.sv
// Shared definitions for the UART loop buffer: mode encodings, TX FSM states,
// the overflow saturation limit and the byte transform helper.
package uart_loop_pkg;

    localparam logic [1:0]  MODE_PASS  = 2'd0;
    localparam logic [1:0]  MODE_UPPER = 2'd1;
    localparam logic [1:0]  MODE_XOR   = 2'd2;
    localparam logic [1:0]  MODE_REV   = 2'd3;

    localparam logic [15:0] OVF_MAX    = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        BUSY = 2'd2
    } tx_state_t;

    function automatic logic [7:0] xform(input logic [7:0] data,
                                         input logic [1:0] mode,
                                         input logic [7:0] key);
        logic [7:0] res;
        res = data;
        case (mode)
            MODE_PASS:  res = data;
            MODE_UPPER: begin
                if ((data >= 8'h61) && (data <= 8'h7A)) begin
                    res = data - 8'h20;
                end else begin
                    res = data;
                end
            end
            MODE_XOR:   res = data ^ key;
            MODE_REV: begin
                for (int i = 0; i < 8; i++) begin
                    res[i] = data[7 - i];
                end
            end
            default:    res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_loop_buffer_if.sv
// Byte path between uart_rx/uart_tx and the loop buffer. The master side is the
// surrounding UART logic; the slave side is the loop buffer itself.
interface uart_loop_buffer_if;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic [1:0] mode;
    logic [7:0] xor_key;
    logic       tx_done;
    logic       tx_dv;
    logic [7:0] tx_byte;

    modport master (
        output rx_dv, rx_byte, mode, xor_key, tx_done,
        input  tx_dv, tx_byte
    );

    modport slave (
        input  rx_dv, rx_byte, mode, xor_key, tx_done,
        output tx_dv, tx_byte
    );
endinterface

// File: rtl/uart_loop_fifo.sv
// Synchronous FIFO with a registered read port. The caller only pushes when a
// slot is free (or a pop happens in the same cycle) and only pops when non-empty.
module uart_loop_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [WIDTH-1:0] rd_data_r;

    // Data storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {(AW + 1){1'b0}};
            rd_data_r <= {WIDTH{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_data_r <= mem_r[rd_ptr_r];
                rd_ptr_r  <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = rd_data_r;
    assign count   = count_r;
    assign full    = (count_r == FULL_COUNT);
    assign empty   = (count_r == {(AW + 1){1'b0}});
endmodule

// File: rtl/uart_loop_buffer.sv
// Buffered, transforming byte loop from uart_rx to uart_tx with a paced TX FSM.
// Define UART_LOOP_STATS_EN to build the overflow counter and high-water mark.
module uart_loop_buffer
    import uart_loop_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int TX_TIMEOUT = 12000
) (
    input  logic                   clock,
    input  logic                   reset,
    uart_loop_buffer_if.slave      bus,
    output logic [$clog2(DEPTH):0] fill,
    output logic [15:0]            overflow_cnt,
    output logic [$clog2(DEPTH):0] hwm,
    output logic                   tx_timeout,
    output logic [7:0]             led
);
    localparam int            FW       = $clog2(DEPTH) + 1;
    localparam int            CW       = $clog2(TX_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TX_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    tx_state_t     state_r;
    tx_state_t     state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          pop_s;
    logic          timeout_s;
    logic          tx_dv_r;
    logic          tx_timeout_r;
    logic          accept_s;
    logic [7:0]    xformed_s;
    logic [7:0]    rd_data_s;
    logic          full_s;
    logic          empty_s;
    logic [FW-1:0] count_s;

    assign xformed_s = xform(bus.rx_byte, bus.mode, bus.xor_key);
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign accept_s  = bus.rx_dv & (~full_s | pop_s);

    uart_loop_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (accept_s),
        .wr_data (xformed_s),
        .pop     (pop_s),
        .rd_data (rd_data_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    // TX FSM next-state: read head in IDLE, launch in SEND, wait for tx_done in BUSY.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pop_s     = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                cnt_s   = {CW{1'b0}};
                state_s = BUSY;
            end
            BUSY: begin
                if (bus.tx_done) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, stall counter and the registered launch/timeout strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            tx_dv_r      <= 1'b0;
            tx_timeout_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            tx_dv_r      <= (state_s == SEND);
            tx_timeout_r <= timeout_s;
        end
    end

`ifdef UART_LOOP_STATS_EN
    logic          drop_s;
    logic [15:0]   ovf_r;
    logic [FW-1:0] hwm_r;

    assign drop_s = bus.rx_dv & ~accept_s;

    // Saturating dropped-byte counter and occupancy high-water mark.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_r <= 16'h0000;
            hwm_r <= {FW{1'b0}};
        end else begin
            if (drop_s && (ovf_r != OVF_MAX)) begin
                ovf_r <= ovf_r + 16'h0001;
            end
            if (count_s > hwm_r) begin
                hwm_r <= count_s;
            end
        end
    end

    assign overflow_cnt = ovf_r;
    assign hwm          = hwm_r;
`else
    assign overflow_cnt = 16'h0000;
    assign hwm          = {FW{1'b0}};
`endif

    // The FIFO read register only changes on a launch, so it doubles as the held TX byte.
    assign bus.tx_dv   = tx_dv_r;
    assign bus.tx_byte = rd_data_s;
    assign led         = rd_data_s;
    assign fill        = count_s;
    assign tx_timeout  = tx_timeout_r;
endmodule
